// File: rtl/axis_palette_loader.sv
// ----------------------------------------------------------------------------
// axis_palette_loader
//   Loads one palette (ENTRIES words) from an AXI4-Stream into one bank of the
//   palette LUT RAM through a BRAM master port. A start pulse arms a single
//   load. The number of beats is checked against TLAST, and the result is
//   reported through sticky error flags and a done pulse.
//
// Ports
//   axis_aclk, axis_aresetn : clock, asynchronous active-low reset
//   start, bank_sel         : arm one load into bank bank_sel (ignored if busy)
//   s_axis_*                : palette entry stream {alpha, R, G, B}
//   lut_ram_*               : BRAM port A master. Byte address is
//                             {0, bank, index, 2'b00}. rdata is unused.
//   busy                    : high while entries are being accepted
//   done                    : one-cycle pulse when a load finishes
//   err_short / err_long    : sticky, TLAST came too early / did not come in time
//   entries_written         : RAM writes issued by the current or last load
// ----------------------------------------------------------------------------
module axis_palette_loader #(
   parameter int ENTRIES   = 256,
   parameter int BANK_BITS = 2,
   parameter int DATA_W    = 32
) (
   input  logic                       axis_aclk,
   input  logic                       axis_aresetn,
   input  logic                       start,
   input  logic [BANK_BITS-1:0]       bank_sel,
   input  logic [DATA_W-1:0]          s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic                       s_axis_tlast,
   output logic                       lut_ram_clk,
   output logic                       lut_ram_ena,
   output logic                       lut_ram_rst,
   output logic [3:0]                 lut_ram_we,
   output logic [31:0]                lut_ram_addr,
   output logic [DATA_W-1:0]          lut_ram_wdata,
   input  logic [DATA_W-1:0]          lut_ram_rdata,
   output logic                       busy,
   output logic                       done,
   output logic                       err_short,
   output logic                       err_long,
   output logic [$clog2(ENTRIES):0]   entries_written
);

   localparam int IDX_W    = $clog2(ENTRIES);
   localparam int ADDR_PAD = 32 - BANK_BITS - IDX_W - 2;
   localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(ENTRIES - 1);
   localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [BANK_BITS-1:0] bank_q;
   logic                 arm;
   logic                 set_short;
   logic                 set_long;
   logic                 wr_p0;
   logic                 unused_rdata;

   assign lut_ram_clk  = axis_aclk;
   assign lut_ram_rst  = 1'b0;
   assign unused_rdata = ^lut_ram_rdata;

   // The write index is the running write count: it never exceeds ENTRIES-1
   // while in LOAD, so no separate index register is needed.
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      arm           = 1'b0;
      set_short     = 1'b0;
      set_long      = 1'b0;
      s_axis_tready = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               arm     = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            s_axis_tready = 1'b1;
            busy          = 1'b1;
            if (s_axis_tvalid) begin
               if (entries_written == LAST_IDX) begin
                  if (s_axis_tlast) begin
                     state_d = S_DONE;
                  end else begin
                     set_long = 1'b1;
                     state_d  = S_DRAIN;
                  end
               end else if (s_axis_tlast) begin
                  set_short = 1'b1;
                  state_d   = S_DONE;
               end
            end
         end
         S_DRAIN: begin
            // Surplus beats are swallowed until TLAST so the stream stays framed.
            s_axis_tready = 1'b1;
            busy          = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---- stage p0: beat accepted while loading -> RAM write next cycle ----
   assign wr_p0 = (state_q == S_LOAD) && s_axis_tvalid;

   // ---- stage p1: registered BRAM write and load status ----
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         bank_q          <= '0;
         entries_written <= '0;
         err_short       <= 1'b0;
         err_long        <= 1'b0;
         lut_ram_ena     <= 1'b0;
         lut_ram_we      <= 4'h0;
         lut_ram_addr    <= '0;
         lut_ram_wdata   <= '0;
      end else begin
         lut_ram_ena <= wr_p0;
         lut_ram_we  <= {4{wr_p0}};
         if (wr_p0) begin
            lut_ram_addr    <= {{ADDR_PAD{1'b0}}, bank_q, entries_written[IDX_W-1:0], 2'b00};
            lut_ram_wdata   <= s_axis_tdata;
            entries_written <= entries_written + CNT_ONE;
         end
         if (arm) begin
            bank_q          <= bank_sel;
            entries_written <= '0;
            err_short       <= 1'b0;
            err_long        <= 1'b0;
         end
         if (set_short) err_short <= 1'b1;
         if (set_long)  err_long  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axis_palette_loader.sv
// ----------------------------------------------------------------------------
// tb_axis_palette_loader
//   Directed bench for axis_palette_loader. The stimulus tasks know, for every
//   beat they put on the stream, whether it must land in the RAM and at which
//   address; a per-cycle compare process checks ready/busy and the BRAM port
//   against that knowledge. Literal expectations pin the address arithmetic.
// ----------------------------------------------------------------------------
module tb_axis_palette_loader;

   logic        axis_aclk;
   logic        axis_aresetn;
   logic        start;
   logic [1:0]  bank_sel;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        s_axis_tlast;
   logic        lut_ram_clk;
   logic        lut_ram_ena;
   logic        lut_ram_rst;
   logic [3:0]  lut_ram_we;
   logic [31:0] lut_ram_addr;
   logic [31:0] lut_ram_wdata;
   logic [31:0] lut_ram_rdata;
   logic        busy;
   logic        done;
   logic        err_short;
   logic        err_long;
   logic [8:0]  entries_written;

   axis_palette_loader dut (
      .axis_aclk       (axis_aclk),
      .axis_aresetn    (axis_aresetn),
      .start           (start),
      .bank_sel        (bank_sel),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .s_axis_tlast    (s_axis_tlast),
      .lut_ram_clk     (lut_ram_clk),
      .lut_ram_ena     (lut_ram_ena),
      .lut_ram_rst     (lut_ram_rst),
      .lut_ram_we      (lut_ram_we),
      .lut_ram_addr    (lut_ram_addr),
      .lut_ram_wdata   (lut_ram_wdata),
      .lut_ram_rdata   (lut_ram_rdata),
      .busy            (busy),
      .done            (done),
      .err_short       (err_short),
      .err_long        (err_long),
      .entries_written (entries_written)
   );

   initial axis_aclk = 1'b0;
   always #5 axis_aclk = ~axis_aclk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state driven by the stimulus: what the stream should see and what
   // the beat currently on the bus must produce in the RAM.
   logic        mdl_ready = 1'b0;
   logic        cur_w     = 1'b0;
   logic [31:0] cur_addr  = '0;
   logic        pend_w    = 1'b0;
   logic [31:0] pend_addr = '0;
   logic [31:0] pend_data = '0;

   int          writes_seen = 0;
   int          done_cnt    = 0;
   logic [31:0] first_addr  = '0;
   logic [31:0] last_addr   = '0;
   logic [31:0] last_data   = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle compare, sampled on the falling edge.
   always @(negedge axis_aclk) begin
      if (!axis_aresetn) begin
         pend_w = 1'b0;
      end else begin
         chk("tready", 32'(s_axis_tready), 32'(mdl_ready));
         chk("busy", 32'(busy), 32'(mdl_ready));
         chk("ena", 32'(lut_ram_ena), 32'(pend_w));
         chk("we", 32'(lut_ram_we), pend_w ? 32'hF : 32'h0);
         chk("ram_rst", 32'(lut_ram_rst), 32'h0);
         if (pend_w && lut_ram_ena) begin
            chk("addr", lut_ram_addr, pend_addr);
            chk("wdata", lut_ram_wdata, pend_data);
         end
         if (lut_ram_ena) begin
            if (writes_seen == 0) first_addr = lut_ram_addr;
            last_addr = lut_ram_addr;
            last_data = lut_ram_wdata;
            writes_seen++;
         end
         if (done) done_cnt++;
         pend_w    = s_axis_tvalid && mdl_ready && cur_w;
         pend_addr = cur_addr;
         pend_data = s_axis_tdata;
      end
   end

   task automatic tick();
      @(posedge axis_aclk);
      #1;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic l, input logic w,
                            input logic [31:0] a, input int gap);
      logic acc;
      int   t;
      if (gap > 0) begin
         s_axis_tvalid = 1'b0;
         repeat (gap) tick();
      end
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      cur_w         = w;
      cur_addr      = a;
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 64) begin
         @(negedge axis_aclk);
         acc = s_axis_tready;
         tick();
         t++;
      end
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL beat_accept: beat 0x%0h not accepted, expected accept within 64 cycles", d);
      end
      cur_w = 1'b0;
   endtask

   task automatic pulse_start(input logic [1:0] bank);
      bank_sel = bank;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      bank_sel = bank + 2'd1;
      mdl_ready = 1'b1;
   endtask

   // One complete load: nbeats beats, TLAST on the final one.
   task automatic run_load(input string nm, input logic [1:0] bank, input int nbeats,
                           input logic gaps, input logic [31:0] pat, input int restart_at);
      int dc;
      int t;
      int exp_n;
      writes_seen = 0;
      dc = done_cnt;
      pulse_start(bank);
      for (int k = 0; k < nbeats; k++) begin
         if (k == restart_at) begin
            start    = 1'b1;
            bank_sel = 2'd0;
         end
         send_beat(32'(k) ^ pat, k == nbeats - 1, k < 256,
                   32'(bank) * 32'd1024 + 32'(k) * 32'd4,
                   gaps ? int'($urandom_range(0, 3)) : 0);
         start = 1'b0;
      end
      mdl_ready     = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      t = 0;
      while (done_cnt == dc && t < 20) begin
         tick();
         t++;
      end
      repeat (3) tick();
      exp_n = (nbeats < 256) ? nbeats : 256;
      chk({nm, "_done_pulses"}, 32'(done_cnt - dc), 32'd1);
      chk({nm, "_writes"}, 32'(writes_seen), 32'(exp_n));
      chk({nm, "_entries_written"}, 32'(entries_written), 32'(exp_n));
      chk({nm, "_err_short"}, 32'(err_short), 32'(nbeats < 256));
      chk({nm, "_err_long"}, 32'(err_long), 32'(nbeats > 256));
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running, expected to finish");
      $fatal(1, "timeout");
   end

   initial begin
      axis_aresetn  = 1'b1;
      start         = 1'b0;
      bank_sel      = 2'd0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      lut_ram_rdata = 32'hDEAD_BEEF;
      #2 axis_aresetn = 1'b0;
      #2;
      chk("rst_tready", 32'(s_axis_tready), 32'h0);
      chk("rst_ena", 32'(lut_ram_ena), 32'h0);
      chk("rst_we", 32'(lut_ram_we), 32'h0);
      chk("rst_addr", lut_ram_addr, 32'h0);
      chk("rst_wdata", lut_ram_wdata, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_err", {30'd0, err_short, err_long}, 32'h0);
      chk("rst_entries", 32'(entries_written), 32'h0);
      repeat (2) tick();
      axis_aresetn = 1'b1;
      repeat (3) tick();

      // Full palette into bank 2, back-to-back.
      run_load("t1", 2'd2, 256, 1'b0, 32'h0, -1);
      chk("t1_first_addr", first_addr, 32'h800);
      chk("t1_last_addr", last_addr, 32'hBFC);
      chk("t1_last_data", last_data, 32'd255);
      chk("t1_entries_lit", 32'(entries_written), 32'd256);

      // Same palette with random valid gaps.
      run_load("t2", 2'd2, 256, 1'b1, 32'h00A5_5A00, -1);
      chk("t2_last_addr", last_addr, 32'hBFC);
      chk("t2_last_data", last_data, 32'h00A5_5AFF);

      // Early TLAST on beat 100, bank 1.
      run_load("t3", 2'd1, 101, 1'b0, 32'h1100_0000, -1);
      chk("t3_first_addr", first_addr, 32'h400);
      chk("t3_last_addr", last_addr, 32'h590);
      chk("t3_err_short_lit", 32'(err_short), 32'h1);

      // 300 beats: 256 written, remainder drained.
      run_load("t4", 2'd0, 300, 1'b0, 32'h2200_0000, -1);
      chk("t4_last_addr", last_addr, 32'h3FC);
      chk("t4_err_long_lit", 32'(err_long), 32'h1);

      // Start re-pulsed mid-load with bank 0: ignored, bank 3 kept, errors cleared.
      run_load("t5", 2'd3, 256, 1'b0, 32'h3300_0000, 10);
      chk("t5_first_addr", first_addr, 32'hC00);
      chk("t5_last_addr", last_addr, 32'hFFC);

      // Reset in the middle of a load.
      writes_seen = 0;
      pulse_start(2'd1);
      for (int k = 0; k <= 50; k++) begin
         send_beat(32'(k), 1'b0, 1'b1, 32'd1024 + 32'(k) * 32'd4, 0);
      end
      chk("t6_ena_before_rst", 32'(lut_ram_ena), 32'h1);
      axis_aresetn = 1'b0;
      mdl_ready    = 1'b0;
      #1;
      chk("t6_rst_ena", 32'(lut_ram_ena), 32'h0);
      chk("t6_rst_we", 32'(lut_ram_we), 32'h0);
      chk("t6_rst_tready", 32'(s_axis_tready), 32'h0);
      chk("t6_rst_busy", 32'(busy), 32'h0);
      chk("t6_rst_entries", 32'(entries_written), 32'h0);
      repeat (2) @(posedge axis_aclk);
      #3 axis_aresetn = 1'b1;
      writes_seen = 0;
      repeat (10) tick();
      chk("t6_no_writes_after_rst", 32'(writes_seen), 32'h0);
      s_axis_tvalid = 1'b0;
      tick();
      run_load("t6_recover", 2'd1, 4, 1'b0, 32'h4400_0000, -1);
      chk("t6_recover_last_addr", last_addr, 32'h40C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
